// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative multiply/divide unit holding the architectural HI/LO registers.
//   MULT/MULTU use shift-add, DIV/DIVU use restoring division; both take one
//   bit per RUN cycle (WIDTH cycles), followed by a single FIX cycle that
//   applies sign correction and writes HI/LO. MTHI/MTLO write HI/LO directly
//   while the unit is idle.
//
//   Build option: define MULDIV_DIV_EN to include the divider. Without it a
//   DIV/DIVU start passes straight to FIX and leaves HI/LO untouched.
//
// Ports
//   clk    in   core clock, rising edge
//   rst_n  in   synchronous active-low reset
//   start  in   launch op (sampled in IDLE only)
//   op     in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   srca   in   multiplicand / dividend, also the MTHI/MTLO source
//   srcb   in   multiplier / divisor
//   mthi   in   write srca into HI
//   mtlo   in   write srca into LO
//   busy   out  operation in progress (RUN or FIX)
//   done   out  one-cycle pulse, HI/LO hold the new result
//   hi     out  HI register
//   lo     out  LO register
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  // Datapath working registers
  logic               div_q, div_d;
  logic               res_neg_q, res_neg_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  // Operand magnitudes: op[0]==0 selects the signed flavour
  logic               signed_op;
  logic [WIDTH-1:0]   abs_a, abs_b;
  assign signed_op = ~op[0];
  assign abs_a     = (signed_op && srca[WIDTH-1]) ? -srca : srca;
  assign abs_b     = (signed_op && srcb[WIDTH-1]) ? -srcb : srcb;

  // Shift-add step: multiplier sits in acc low half and shifts out LSB first,
  // the product grows in from the top with the carry of the partial sum.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, prod_fix;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign prod_fix = res_neg_q ? -acc_q : acc_q;

`ifdef MULDIV_DIV_EN
  // Restoring step: dividend shifts out of acc low half MSB first while the
  // quotient bits shift in at the LSB. The partial remainder is always below
  // the divisor, so WIDTH bits hold it; only the shifted trial value needs
  // WIDTH+1.
  logic               dvd_neg_q, dvd_neg_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH:0]     rem_shift;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_next, quo_fix, rem_fix;
  assign rem_shift = {rem_q, acc_q[WIDTH-1]};
  assign q_bit     = (rem_shift >= {1'b0, opb_q});
  assign rem_next  = q_bit ? WIDTH'(rem_shift - {1'b0, opb_q}) : rem_shift[WIDTH-1:0];
  assign quo_fix   = res_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  // With a zero divisor every trial succeeds, so the remainder ends up equal
  // to the dividend magnitude and re-applying the dividend sign recovers srca.
  assign rem_fix   = dvd_neg_q ? -rem_q : rem_q;
`endif

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case leaves it unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    div_d     = div_q;
    res_neg_d = res_neg_q;
    opb_d     = opb_q;
    acc_d     = acc_q;
`ifdef MULDIV_DIV_EN
    dvd_neg_d = dvd_neg_q;
    rem_d     = rem_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // start wins over a simultaneous MTHI/MTLO
          div_d     = op[1];
          res_neg_d = signed_op & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
          opb_d     = abs_b;
          acc_d     = {{WIDTH{1'b0}}, abs_a};
          cnt_d     = '0;
          state_d   = S_RUN;
`ifdef MULDIV_DIV_EN
          dvd_neg_d = signed_op & srca[WIDTH-1];
          rem_d     = '0;
`else
          if (op[1]) state_d = S_FIX;
`endif
        end else begin
          if (mthi) hi_d = srca;
          if (mtlo) lo_d = srca;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
`ifdef MULDIV_DIV_EN
        if (div_q) begin
          rem_d = rem_next;
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], q_bit};
        end else begin
          acc_d = mul_next;
        end
`else
        acc_d = mul_next;
`endif
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
`ifdef MULDIV_DIV_EN
        else begin
          // Divide by zero: quotient is already all ones, skip its negation
          lo_d = (opb_q == '0) ? '1 : quo_fix;
          hi_d = rem_fix;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; the combinational block above uses blocking ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // NOTE: the datapath registers are left without reset; they are always
  // loaded at start before being read, and an aborted result never reaches HI/LO.
  always_ff @(posedge clk) begin
    div_q     <= div_d;
    res_neg_q <= res_neg_d;
    opb_q     <= opb_d;
    acc_q     <= acc_d;
`ifdef MULDIV_DIV_EN
    dvd_neg_q <= dvd_neg_d;
    rem_q     <= rem_d;
`endif
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Self-checking bench for muldiv_unit. Each launched operation pushes its
//   expected HI/LO and done cycle onto a queue; a negedge monitor pops and
//   compares whenever done pulses. Divide cases are exercised according to
//   whether MULDIV_DIV_EN is defined.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srca, srcb;
  logic        mthi, mtlo;
  logic        busy, done;
  logic [31:0] hi, lo;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .srca  (srca),
    .srcb  (srcb),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // cyc == k between rising edges k and k+1
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: returns {hi, lo} after op given the current HI/LO.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb_v;
    logic [63:0] r;
    int qa, qb;
    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    r    = {m_hi, m_lo};
    case (o)
      2'b00: r = 64'(sa * sb_v);
      2'b01: r = {32'b0, a} * {32'b0, b};
`ifdef MULDIV_DIV_EN
      2'b10: begin
        qa = $signed(a);
        qb = $signed(b);
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else r = {32'(qa % qb), 32'(qa / qb)};
      end
      2'b11: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
`endif
      default: r = {m_hi, m_lo};
    endcase
    return r;
  endfunction

  // Called at a negedge; drives start for one cycle and returns at the
  // negedge of the following cycle.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    int lat;
    r   = model(o, a, b);
    lat = 34;
`ifndef MULDIV_DIV_EN
    if (o[1]) lat = 2;
`endif
    start = 1'b1;
    op    = o;
    srca  = a;
    srcb  = b;
    sb.push_back('{r[63:32], r[31:0], cyc + lat});
    m_hi = r[63:32];
    m_lo = r[31:0];
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (done !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", {63'b0, done}, 64'd1);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {63'b0, done}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("res_hi", {32'b0, hi}, {32'b0, mon_e.hi});
        check("res_lo", {32'b0, lo}, {32'b0, mon_e.lo});
        check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
        check("busy_in_done", {63'b0, busy}, 64'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic [31:0] old_v;
    logic [31:0] ra, rb;
    logic [1:0]  ro;

    rst_n = 1'b0; start = 1'b0; op = '0; srca = '0; srcb = '0; mthi = 1'b0; mtlo = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hi",   {32'b0, hi}, 64'd0);
    check("rst_lo",   {32'b0, lo}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    rst_n = 1'b1;

    // MULTU max x max with busy window
    @(negedge clk);
    n0 = cyc;
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("busy_first", {63'b0, busy}, 64'd1);
    repeat (32) @(negedge clk);
    check("busy_last_cycle", 64'(cyc - n0), 64'd33);
    check("busy_last", {63'b0, busy}, 64'd1);
    @(negedge clk);
    check("busy_after", {63'b0, busy}, 64'd0);

    // MULT -3 x 5, then back-to-back launch in the done cycle
    @(negedge clk);
    launch(2'b00, -32'sd3, 32'd5);
    wait_done(40);
`ifdef MULDIV_DIV_EN
    launch(2'b10, -32'sd7, 32'd2);
`else
    launch(2'b01, 32'd7, 32'd9);
`endif
    wait_done(40);

`ifdef MULDIV_DIV_EN
    @(negedge clk);
    launch(2'b11, 32'd100, 32'd0);
    wait_done(40);
    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(40);
    launch(2'b10, 32'd7, -32'sd2);
    wait_done(40);
`endif

    // MTHI in idle
    @(negedge clk);
    mthi = 1'b1; srca = 32'h1234;
    @(negedge clk);
    mthi = 1'b0;
    m_hi = 32'h1234;
    check("mthi_write", {32'b0, hi}, 64'h1234);

    // start together with mthi: move dropped
    old_v = m_hi;
    mthi  = 1'b1;
    launch(2'b01, 32'd3, 32'd4);
    mthi  = 1'b0;
    check("mthi_dropped", {32'b0, hi}, {32'b0, old_v});
    wait_done(40);

    // MTLO and start during RUN ignored
    @(negedge clk);
    old_v = lo;
    n0 = cyc;
    launch(2'b01, 32'd6, 32'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b01; srca = 32'hDEAD; srcb = 32'd1; mtlo = 1'b1;
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0;
    check("mtlo_in_run", {32'b0, lo}, {32'b0, old_v});
    wait_done(40);
    check("run_done_cycle", 64'(cyc - n0), 64'd34);

    // Reset mid-operation
    @(negedge clk);
    launch(2'b01, 32'd7, 32'd9);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_hi", {32'b0, hi}, 64'd0);
    check("abort_lo", {32'b0, lo}, 64'd0);
    repeat (40) @(negedge clk);
    launch(2'b01, 32'd7, 32'd9);
    wait_done(40);

    // DIVU with HI=LO=0x55 preloaded via simultaneous MTHI/MTLO
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; srca = 32'h55;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    m_hi = 32'h55; m_lo = 32'h55;
    check("mtboth_hi", {32'b0, hi}, 64'h55);
    check("mtboth_lo", {32'b0, lo}, 64'h55);
    launch(2'b11, 32'd10, 32'd3);
    check("divu_busy", {63'b0, busy}, 64'd1);
    wait_done(40);

    // Random back-to-back operations
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ra = $urandom();
      rb = $urandom();
      ro = 2'($urandom_range(0, 3));
      if (rb == 0) rb = 32'd1;
      launch(ro, ra, rb);
      wait_done(40);
    end

    repeat (5) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS core. It sits beside the ALU, downstream of the register file's two read ports: operands come from `rd1`/`rd2`. It feeds the register-file write path, supplying HI/LO for MFHI/MFLO through the existing result mux. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO, and provides a `busy` signal the controller uses to stall.

## Interface
- `WIDTH`, default 32: operand and HI/LO width. Iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  launch operation `op`; sampled only in IDLE.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `srca`  in  WIDTH  multiplicand or dividend (from `rd1`).
- `srcb`  in  WIDTH  multiplier or divisor (from `rd2`).
- `mthi`  in  1  write `srca` into HI (MTHI).
- `mtlo`  in  1  write `srca` into LO (MTLO).
- `busy`  out  1  operation in progress; the controller stalls MFHI/MFLO/start.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- **Reset** (`rst_n`=0 at an edge):
  - State goes to IDLE.
  - `hi`=0, `lo`=0, `busy`=0, `done`=0, iteration counter=0.
  - Reset mid-operation aborts the operation; no partial result is written.
- **States:**
  - IDLE → RUN on `start`.
  - RUN → FIX when the counter reaches `WIDTH`-1.
  - FIX → IDLE unconditionally.
- **Operand capture (IDLE, `start`):**
  - Latch the operands. For the signed ops, latch magnitudes (two's-complement absolute value).
  - Record the result sign (`srca[31]^srcb[31]`) and the dividend sign.
- **Multiply:** shift-add, one multiplier bit per RUN cycle, into a 2·WIDTH accumulator.
- **Divide:** restoring division, one quotient bit per RUN cycle; remainder in WIDTH+1 bits.
- **FIX:**
  - Apply sign correction:
    - product negated if the result sign is set;
    - quotient negated if the result sign is set;
    - remainder takes the sign of the dividend.
  - Write HI/LO: multiply gives HI=upper half, LO=lower half; divide gives LO=quotient, HI=remainder.
  - Register `done`=1.
- **Divide by zero:** LO=all ones, HI=`srca` unmodified; sign correction is skipped.
- **Overflow:** DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- **MTHI/MTLO:**
  - Honoured only in IDLE with `start`=0, written at the edge.
  - Ignored while `busy`.
  - `mthi` and `mtlo` both high writes both registers.
- **Ignored and simultaneous events:**
  - `start` while `busy` is ignored.
  - `start` together with `mthi`/`mtlo` in IDLE: `start` wins and the move is dropped.

## Timing
- `start` high in cycle N gives:
  - RUN in cycles N+1..N+32;
  - FIX in cycle N+33;
  - `hi`/`lo` updated and `done`=1 in cycle N+34.
- `busy`=1 in cycles N+1..N+33. `busy` is 0 in the `done` cycle.
- Back-to-back operation: a new `start` is accepted in the `done` cycle.
- `hi`/`lo` are registered outputs, stable except at the FIX edge or an MTHI/MTLO edge.
- MTHI/MTLO takes effect on the next edge; the value is visible in the following cycle.

## Configuration
- Macro `MULDIV_DIV_EN`.
- **Defined:** DIV and DIVU are implemented as described above.
- **Undefined:**
  - Divider datapath is removed.
  - `start` with `op`=10/11 goes IDLE → FIX directly: `busy`=1 for one cycle, `done` in cycle N+2.
  - HI/LO are unchanged.
  - Multiply behaviour is identical in both builds.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, start in cycle 0 → `busy` in cycles 1–33; `done` in cycle 34 with `hi`=0xFFFFFFFE, `lo`=0x00000001.
- MULT −3 × 5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1; then DIV −7 / 2 issued in the `done` cycle → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU 100 / 0 → `lo`=0xFFFFFFFF, `hi`=0x00000064. DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- MTHI 0x1234 in IDLE → `hi`=0x1234 next cycle. MTLO asserted during RUN → `lo` unchanged. `start` asserted in cycle 5 of RUN → ignored; `done` still arrives at cycle 34.
- MULTU 7 × 9 with `rst_n`=0 at cycle 10 → `busy`=0, `hi`=`lo`=0, no `done`. A new MULTU 7 × 9 started afterwards → `lo`=63, `hi`=0.
- Build without `MULDIV_DIV_EN`: DIVU 10 / 3 with `hi`=`lo`=0x55 beforehand → `done` in cycle 2, `hi`=`lo`=0x55.
